idex_operand_stage: RTL

ID/EX pipeline stage that sits directly upstream of the execute-stage ALU. It registers one decoded instruction per accepted handshake. It resolves operand hazards by forwarding from the MEM and WB stages. It stalls on load-use dependencies and presents registered `alu_a`/`alu_b`/`alu_ctrl` to the ALU along with the destination and store-data side-band. Flush support lets branch resolution kill the wrong-path instruction held here.

---
 rtl/idex_operand_stage_if.sv | 57 +++++
 rtl/idex_operand_stage.sv | 116 +++++++++++
 2 files changed

// File: rtl/idex_operand_stage_if.sv
// ID/EX operand stage bundle: decode-side request, forwarding taps, and ALU-side outputs.
// The stage itself connects through the slave modport; the decode/execute side uses master.
interface idex_operand_stage_if #(
  parameter int BIT_WIDTH = 32
);
  logic                 in_valid;
  logic                 in_ready;
  logic [BIT_WIDTH-1:0] in_pc;
  logic [BIT_WIDTH-1:0] in_imm;
  logic [4:0]           in_rs1_addr;
  logic [4:0]           in_rs2_addr;
  logic [4:0]           in_rd_addr;
  logic [BIT_WIDTH-1:0] in_rs1_data;
  logic [BIT_WIDTH-1:0] in_rs2_data;
  logic [3:0]           in_alu_ctrl;
  logic                 in_a_sel;
  logic                 in_b_sel;
  logic                 in_rd_we;
  logic                 in_is_load;
  logic                 flush;
  logic                 ex_ready;
  logic                 fwd_mem_we;
  logic                 fwd_mem_is_load;
  logic [4:0]           fwd_mem_rd;
  logic [BIT_WIDTH-1:0] fwd_mem_data;
  logic                 fwd_wb_we;
  logic [4:0]           fwd_wb_rd;
  logic [BIT_WIDTH-1:0] fwd_wb_data;
  logic                 out_valid;
  logic [BIT_WIDTH-1:0] alu_a;
  logic [BIT_WIDTH-1:0] alu_b;
  logic [3:0]           alu_ctrl;
  logic [4:0]           out_rd_addr;
  logic                 out_rd_we;
  logic                 out_is_load;
  logic [BIT_WIDTH-1:0] out_store_data;

  modport slave (
    input  in_valid, in_pc, in_imm, in_rs1_addr, in_rs2_addr, in_rd_addr,
           in_rs1_data, in_rs2_data, in_alu_ctrl, in_a_sel, in_b_sel,
           in_rd_we, in_is_load, flush, ex_ready,
           fwd_mem_we, fwd_mem_is_load, fwd_mem_rd, fwd_mem_data,
           fwd_wb_we, fwd_wb_rd, fwd_wb_data,
    output in_ready, out_valid, alu_a, alu_b, alu_ctrl,
           out_rd_addr, out_rd_we, out_is_load, out_store_data
  );

  modport master (
    output in_valid, in_pc, in_imm, in_rs1_addr, in_rs2_addr, in_rd_addr,
           in_rs1_data, in_rs2_data, in_alu_ctrl, in_a_sel, in_b_sel,
           in_rd_we, in_is_load, flush, ex_ready,
           fwd_mem_we, fwd_mem_is_load, fwd_mem_rd, fwd_mem_data,
           fwd_wb_we, fwd_wb_rd, fwd_wb_data,
    input  in_ready, out_valid, alu_a, alu_b, alu_ctrl,
           out_rd_addr, out_rd_we, out_is_load, out_store_data
  );
endinterface

// File: rtl/idex_operand_stage.sv
// ID/EX register stage: MEM/WB operand forwarding, load-use stall, flush, and
// registered ALU operands with rd/store-data side-band for the execute stage.
module idex_operand_stage #(
  parameter int BIT_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  idex_operand_stage_if.slave   bus
);
  typedef logic [BIT_WIDTH-1:0] word_t;

  // MEM wins over WB; a MEM load has no data yet, so it is never a forward source.
  function automatic word_t fwd_sel(
    input logic [4:0] r,
    input word_t      rf_data,
    input logic       mem_we,
    input logic       mem_ld,
    input logic [4:0] mem_rd,
    input word_t      mem_data,
    input logic       wb_we,
    input logic [4:0] wb_rd,
    input word_t      wb_data
  );
    word_t v;
    if (r == 5'd0)                                v = '0;
    else if (mem_we && !mem_ld && mem_rd == r)    v = mem_data;
    else if (wb_we && wb_rd == r)                 v = wb_data;
    else                                          v = rf_data;
    return v;
  endfunction

  logic       out_valid_q, out_valid_d;
  word_t      alu_a_q, alu_a_d;
  word_t      alu_b_q, alu_b_d;
  logic [3:0] alu_ctrl_q, alu_ctrl_d;
  logic [4:0] rd_addr_q, rd_addr_d;
  logic       rd_we_q, rd_we_d;
  logic       is_load_q, is_load_d;
  word_t      store_data_q, store_data_d;

  word_t rs1_fwd, rs2_fwd;
  logic  hazard, in_ready, accept;

  always_comb begin
    rs1_fwd = fwd_sel(bus.in_rs1_addr, bus.in_rs1_data, bus.fwd_mem_we, bus.fwd_mem_is_load,
                      bus.fwd_mem_rd, bus.fwd_mem_data, bus.fwd_wb_we, bus.fwd_wb_rd,
                      bus.fwd_wb_data);
    rs2_fwd = fwd_sel(bus.in_rs2_addr, bus.in_rs2_data, bus.fwd_mem_we, bus.fwd_mem_is_load,
                      bus.fwd_mem_rd, bus.fwd_mem_data, bus.fwd_wb_we, bus.fwd_wb_rd,
                      bus.fwd_wb_data);

    // rs2 counts as used even for immediate forms; costs a rare extra stall.
    hazard = bus.in_valid && bus.fwd_mem_we && bus.fwd_mem_is_load && (bus.fwd_mem_rd != 5'd0)
             && (((bus.fwd_mem_rd == bus.in_rs1_addr) && !bus.in_a_sel)
                 || (bus.fwd_mem_rd == bus.in_rs2_addr));

    in_ready = !bus.flush && !hazard && (!out_valid_q || bus.ex_ready);
    accept   = bus.in_valid && in_ready;

    out_valid_d  = out_valid_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_ctrl_d   = alu_ctrl_q;
    rd_addr_d    = rd_addr_q;
    rd_we_d      = rd_we_q;
    is_load_d    = is_load_q;
    store_data_d = store_data_q;

    if (bus.flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d  = 1'b1;
      alu_a_d      = bus.in_a_sel ? bus.in_pc  : rs1_fwd;
      alu_b_d      = bus.in_b_sel ? bus.in_imm : rs2_fwd;
      alu_ctrl_d   = bus.in_alu_ctrl;
      rd_addr_d    = bus.in_rd_addr;
      rd_we_d      = bus.in_rd_we;
      is_load_d    = bus.in_is_load;
      store_data_d = rs2_fwd;
    end else if (out_valid_q && bus.ex_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_ctrl_q   <= 4'b0000;
      rd_addr_q    <= 5'd0;
      rd_we_q      <= 1'b0;
      is_load_q    <= 1'b0;
      store_data_q <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_ctrl_q   <= alu_ctrl_d;
      rd_addr_q    <= rd_addr_d;
      rd_we_q      <= rd_we_d;
      is_load_q    <= is_load_d;
      store_data_q <= store_data_d;
    end
  end

  assign bus.in_ready       = in_ready;
  assign bus.out_valid      = out_valid_q;
  assign bus.alu_a          = alu_a_q;
  assign bus.alu_b          = alu_b_q;
  assign bus.alu_ctrl       = alu_ctrl_q;
  assign bus.out_rd_addr    = rd_addr_q;
  assign bus.out_rd_we      = rd_we_q;
  assign bus.out_is_load    = is_load_q;
  assign bus.out_store_data = store_data_q;
endmodule
